uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//  Buffered UART transmitter; companion to the UART receive path in UART_controller.
//  Accepts bytes on a valid/ready interface into a FIFO, then serializes them 8N1 (or 8N2) LSB-first on UART_TXD.
//  Frames are sent back-to-back while the FIFO holds data, so host-side TX logic never stalls per byte.
// PARAMETERS
//  CLKS_PER_BIT  868  CLK cycles per UART bit (100 MHz / 115200); legal range >= 4
//  FIFO_DEPTH    16   byte entries; power of 2, >= 2
//  STOP_BITS     1    stop bits per frame; 1 or 2
// PORTS
//  CLK         in   1                       system clock; single clock domain, all logic on rising edge
//  RST         in   1                       synchronous, active-low reset
//  TX_DAT      in   8                       byte to enqueue
//  TX_VALID    in   1                       TX_DAT valid this cycle
//  TX_READY    out  1                       FIFO can accept a byte this cycle (registered)
//  UART_TXD    out  1                       serial output, idle high
//  TX_BUSY     out  1                       high while a frame is on the line (START..STOP)
//  TX_DONE     out  1                       1-cycle pulse on the last cycle of each frame's stop period
//  FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1    bytes held in FIFO (excludes the byte in the shifter)
// BEHAVIOUR
//  Reset (RST=0 at an edge): UART_TXD=1, TX_READY=0, TX_BUSY=0, TX_DONE=0, FIFO_COUNT=0;
//   FIFO pointers cleared, FSM->IDLE. TX_READY rises on the first edge with RST=1.
//  Reset mid-frame: frame is truncated; UART_TXD=1 from the reset edge; no TX_DONE; queued bytes discarded.
//  Enqueue: byte written when TX_VALID & TX_READY at an edge. TX_VALID while TX_READY=0 is ignored;
//   producer holds TX_DAT/TX_VALID until accepted.
//  TX_READY(next) = !(count_next == FIFO_DEPTH), using count after this cycle's push/pop.
//  Simultaneous push+pop: FIFO_COUNT unchanged; both take effect. Pointers wrap modulo FIFO_DEPTH.
//  Pop only when FIFO_COUNT>0; a byte pushed into an empty FIFO becomes visible one edge later.
//  FSM states: IDLE, START, DATA, STOP. One bit counter 0..CLKS_PER_BIT-1; one bit index 0..7.
//   IDLE : UART_TXD=1. If FIFO_COUNT>0: pop into shifter, go START.
//   START: UART_TXD=0 for CLKS_PER_BIT cycles, then DATA with index 0.
//   DATA : UART_TXD=shift[0] for CLKS_PER_BIT cycles per bit; shift right; after bit 7 go STOP.
//   STOP : UART_TXD=1 for STOP_BITS*CLKS_PER_BIT cycles; TX_DONE=1 on the last cycle.
//          On that cycle: if FIFO_COUNT>0, pop and go directly to START (no idle gap), else go IDLE.
//  Latency: accept edge k into empty FIFO with FSM IDLE -> UART_TXD falls at edge k+2.
//  Frame length: (9+STOP_BITS)*CLKS_PER_BIT cycles exactly. TX_BUSY=1 in START/DATA/STOP.
//  All outputs registered; UART_TXD is glitch-free (driven from a flop).
// STRUCTURE
//  Shared header my_header.vh: UART_DATA_BITS=8, default CLKS_PER_BIT, FSM state encodings
//   (UART_TX_IDLE/START/DATA/STOP). RX and TX blocks use the same header.
//  One sub-module: sync_fifo (width 8, depth FIFO_DEPTH, count output, push/pop, sync active-low reset).
//  Top level holds the FSM, bit timer, bit index and shifter only.
// TESTING  (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=16, STOP_BITS=1 unless stated)
//  1 Hold RST=0 3 cycles -> UART_TXD=1, TX_READY=0, FIFO_COUNT=0, TX_DONE=0; TX_READY=1 one edge after release.
//  2 Push 0xA5 once -> start bit at accept+2; data 1,0,1,0,0,1,0,1 at 4 cycles each; stop 4 cycles;
//    single TX_DONE pulse; TX_BUSY high for exactly 40 cycles.
//  3 Push 0x00 then 0xFF back-to-back -> 2nd start bit begins on the edge after the 1st TX_DONE;
//    TX_DONE pulses exactly 40 cycles apart; UART_TXD never idles between frames.
//  4 Hold TX_VALID with 0x00..0x13 incrementing on accept -> FIFO_COUNT peaks at 16, TX_READY=0 while full;
//    the line decodes to exactly 0x00..0x13 in order, with no loss or duplication.
//  5 Pull RST=0 for 1 cycle during DATA bit 3 with 5 bytes queued -> UART_TXD=1 from the reset edge,
//    FIFO_COUNT=0, no TX_DONE, line stays idle afterwards.
//  6 FIFO_COUNT=1 and push coincides with STOP-end pop -> FIFO_COUNT stays 1; next frame starts with no gap.
//    Repeat test 2 with STOP_BITS=2 -> stop=8 cycles, frame=44 cycles.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// uart_tx_buffered_pkg: shared UART constants, TX FSM state encoding and sizing helper
package uart_tx_buffered_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  typedef enum logic [1:0] {
    UART_TX_IDLE,
    UART_TX_START,
    UART_TX_DATA,
    UART_TX_STOP
  } tx_state_t;
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// uart_tx_buffered_sync_fifo: byte FIFO with occupancy count and registered ready
module uart_tx_buffered_sync_fifo
  import uart_tx_buffered_pkg::*;
#(
  parameter int WIDTH = UART_DATA_BITS,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic                          ready,
  output logic [count_width(DEPTH)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  logic [CW-1:0] count_next;
  assign wr = push && ready;
  assign rd = pop && count != '0;
  assign count_next = count + CW'(wr) - CW'(rd);
  assign rdata = mem[rptr];
  // storage array; contents need no reset since count gates every read
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= wdata;
  // pointers wrap naturally; ready looks at the post-update count so it never overfills
  always_ff @(posedge clk)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ready <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count_next;
      ready <= count_next != CW'(DEPTH);
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-backed 8N1/8N2 UART transmitter sending frames back-to-back
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [UART_DATA_BITS-1:0]          TX_DAT,
  input  logic                               TX_VALID,
  output logic                               TX_READY,
  output logic                               UART_TXD,
  output logic                               TX_BUSY,
  output logic                               TX_DONE,
  output logic [count_width(FIFO_DEPTH)-1:0] FIFO_COUNT
);
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(STOP_CLKS);
  localparam int IW = $clog2(UART_DATA_BITS);
  tx_state_t state;
  logic [TW-1:0] timer;
  logic [IW-1:0] idx;
  logic [UART_DATA_BITS-1:0] shift, head;
  logic bit_end, stop_end, pop;
  assign bit_end  = timer == TW'(CLKS_PER_BIT - 1);
  assign stop_end = timer == TW'(STOP_CLKS - 1);
  assign pop = FIFO_COUNT != '0 && (state == UART_TX_IDLE || (state == UART_TX_STOP && stop_end));

  uart_tx_buffered_sync_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) fifo (
    .clk  (CLK),
    .rst_n(RST),
    .push (TX_VALID),
    .pop  (pop),
    .wdata(TX_DAT),
    .rdata(head),
    .ready(TX_READY),
    .count(FIFO_COUNT)
  );

  // frame sequencer; line outputs are flops of the current state so they trail it by one cycle
  always_ff @(posedge CLK)
    if (!RST) begin
      state    <= UART_TX_IDLE;
      timer    <= '0;
      idx      <= '0;
      shift    <= '0;
      UART_TXD <= 1'b1;
      TX_BUSY  <= 1'b0;
      TX_DONE  <= 1'b0;
    end else begin
      UART_TXD <= state == UART_TX_START ? 1'b0 : state == UART_TX_DATA ? shift[0] : 1'b1;
      TX_BUSY  <= state != UART_TX_IDLE;
      TX_DONE  <= state == UART_TX_STOP && stop_end;
      case (state)
        UART_TX_IDLE:
          if (pop) begin
            shift <= head;
            timer <= '0;
            state <= UART_TX_START;
          end
        UART_TX_START:
          if (bit_end) begin
            timer <= '0;
            idx   <= '0;
            state <= UART_TX_DATA;
          end else timer <= timer + 1'b1;
        UART_TX_DATA:
          if (bit_end) begin
            timer <= '0;
            shift <= shift >> 1;
            idx   <= idx + 1'b1;
            if (idx == IW'(UART_DATA_BITS - 1)) state <= UART_TX_STOP;
          end else timer <= timer + 1'b1;
        UART_TX_STOP:
          if (stop_end) begin
            timer <= '0;
            if (pop) begin
              shift <= head;
              state <= UART_TX_START;
            end else state <= UART_TX_IDLE;
          end else timer <= timer + 1'b1;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench decoding the serial line against queued bytes
module tb_uart_tx_buffered;
  localparam int CPB    = 4;
  localparam int DEPTH  = 16;
  localparam int FRAME  = 10 * CPB;
  localparam int FRAME2 = 11 * CPB;

  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] dat = '0, dat2 = '0;
  logic valid = 1'b0, valid2 = 1'b0;
  logic ready, txd, busy, done, ready2, txd2, busy2, done2;
  logic [4:0] cnt, cnt2;

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int done_q[$];
  int idle_bad = 0, acc_edge = 0;
  bit stat_en = 1'b0;
  int busy_cnt = 0, done_cnt = 0, max_cnt = 0, full_ready = 0;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .CLK(clk), .RST(rst), .TX_DAT(dat), .TX_VALID(valid), .TX_READY(ready),
    .UART_TXD(txd), .TX_BUSY(busy), .TX_DONE(done), .FIFO_COUNT(cnt)
  );
  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .CLK(clk), .RST(rst), .TX_DAT(dat2), .TX_VALID(valid2), .TX_READY(ready2),
    .UART_TXD(txd2), .TX_BUSY(busy2), .TX_DONE(done2), .FIFO_COUNT(cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (stat_en) begin
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
      if (cnt == 5'd16 && ready === 1'b1) full_ready++;
    end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    dat = b;
    valid = 1'b1;
    while (ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %h never accepted", b);
        valid = 1'b0;
        return;
      end
    end
    acc_edge = cyc + 1;
    exp_q.push_back(b);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 || busy !== 1'b0 || cnt !== 5'd0) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout: %0d bytes still pending", exp_q.size());
        return;
      end
    end
  endtask

  // line monitor: a frame is low start, 8 data bits LSB first, high stop, CPB cycles each
  initial begin
    logic [7:0] want, got;
    logic line;
    int bad;
    bit aborted;
    forever begin
      @(negedge clk);
      if (!rst) continue;
      if (txd !== 1'b0) begin
        if (busy !== 1'b0 || done !== 1'b0) idle_bad++;
        continue;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: line started a frame with nothing queued (cycle %0d)", cyc);
        want = '0;
      end else want = exp_q.pop_front();
      got = '0;
      bad = 0;
      aborted = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
        if (c > 0) @(negedge clk);
        if (!rst) begin
          aborted = 1'b1;
          break;
        end
        line = c < CPB ? 1'b0 : c < 9 * CPB ? want[(c - CPB) / CPB] : 1'b1;
        if (txd !== line || busy !== 1'b1 || done !== (c == FRAME - 1)) bad++;
        if (c >= CPB && c < 9 * CPB && (c % CPB) == CPB / 2) got[(c - CPB) / CPB] = txd;
        if (c == FRAME - 1 && done === 1'b1) done_q.push_back(cyc);
      end
      if (!aborted) begin
        chk("frame_byte", 32'(got), 32'(want));
        chk("frame_wave", bad, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, bad, bsum, dsum;
    logic [7:0] b3, pat;
    logic line;
    // reset state and ready release
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_ready", ready, 0);
    chk("rst_count", cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", ready, 1);
    chk("ready2_after_rst", ready2, 1);
    // single byte: latency, busy length, one done pulse
    busy_cnt = 0;
    done_cnt = 0;
    stat_en = 1'b1;
    send(8'hA5);
    a = acc_edge;
    chk("lat_accept", txd, 1);
    wait_to(a + 1);
    chk("lat_pre", txd, 1);
    wait_to(a + 2);
    chk("lat_start", txd, 0);
    wait_to(a + 2 + FRAME + 10);
    stat_en = 1'b0;
    chk("busy_cycles", busy_cnt, FRAME);
    chk("done_pulses", done_cnt, 1);
    // back-to-back frames
    done_q.delete();
    send(8'h00);
    send(8'hFF);
    wait_idle();
    chk("b2b_dones", done_q.size(), 2);
    if (done_q.size() == 2) chk("b2b_spacing", done_q[1] - done_q[0], FRAME);
    // fill the FIFO with a held valid
    max_cnt = 0;
    full_ready = 0;
    stat_en = 1'b1;
    for (int i = 0; i < 20; i++) send(8'(i));
    wait_idle();
    stat_en = 1'b0;
    chk("fifo_peak", max_cnt, DEPTH);
    chk("ready_low_when_full", full_ready, 0);
    // push coinciding with the stop-end pop
    send(8'($urandom));
    a = acc_edge;
    send(8'($urandom));
    wait_to(a + 40);
    chk("coincide_pre_count", cnt, 1);
    b3 = 8'($urandom);
    dat = b3;
    valid = 1'b1;
    exp_q.push_back(b3);
    @(negedge clk);
    valid = 1'b0;
    chk("coincide_done", done, 1);
    chk("coincide_count", cnt, 1);
    wait_to(a + 42);
    chk("coincide_count_next", cnt, 1);
    chk("coincide_no_gap", txd, 0);
    wait_idle();
    // reset during data bit 3 with five bytes queued
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom));
      if (i == 0) a = acc_edge;
    end
    wait_to(a + 18);
    chk("q5_count", cnt, 5);
    #1 rst = 1'b0;
    wait_to(a + 19);
    chk("midrst_txd", txd, 1);
    chk("midrst_count", cnt, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 0);
    exp_q.delete();
    #1 rst = 1'b1;
    wait_to(a + 20);
    chk("midrst_ready_back", ready, 1);
    busy_cnt = 0;
    done_cnt = 0;
    stat_en = 1'b1;
    repeat (100) @(negedge clk);
    stat_en = 1'b0;
    chk("post_rst_done", done_cnt, 0);
    chk("post_rst_busy", busy_cnt, 0);
    chk("post_rst_count", cnt, 0);
    send(8'h3C);
    wait_idle();
    // random bursts with random gaps
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle();
    // two stop bits: 44-cycle frame, 8-cycle stop
    chk("stop2_ready", ready2, 1);
    pat = 8'hA5;
    dat2 = pat;
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    a = cyc;
    bad = 0;
    bsum = 0;
    dsum = 0;
    wait_to(a + 1);
    chk("stop2_lat_pre", txd2, 1);
    for (int c = 0; c < FRAME2 + 4; c++) begin
      wait_to(a + 2 + c);
      line = c < CPB ? 1'b0 : c < 9 * CPB ? pat[(c - CPB) / CPB] : 1'b1;
      if (txd2 !== line || done2 !== (c == FRAME2 - 1)) bad++;
      bsum += int'(busy2);
      dsum += int'(done2);
    end
    chk("stop2_wave", bad, 0);
    chk("stop2_busy", bsum, FRAME2);
    chk("stop2_done", dsum, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("idle_clean", idle_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
